// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencing controller.
// Holds the 3-bit state encoding, the key idle level and the short debounce
// length used when simulating (the board build uses the full 10 ms value).
package stopwatch_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StStop    = 3'd2,
    StLapRun  = 3'd3,
    StLapStop = 3'd4
  } sw_state_e;

  // Debounce length for simulation builds.
  localparam int unsigned SimDebounceCycles = 4;

  // Raw keys are active-low, so the released level is high.
  localparam logic KeyReleased = 1'b1;

  function automatic logic state_is_running(sw_state_e s);
    return (s == StRun) || (s == StLapRun);
  endfunction

  function automatic logic state_is_lap(sw_state_e s);
    return (s == StLapRun) || (s == StLapStop);
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Conditions one raw active-low pushbutton.
// 2-FF synchroniser, then a level is accepted once DEBOUNCE_CYCLES consecutive
// identical synchronised samples have been seen. An accepted high-to-low
// transition gives one 1-cycle press pulse, DEBOUNCE_CYCLES+3 clocks after a
// stable low edge. A press is only honoured after a release has been accepted,
// so a key held through reset stays ignored until released and pressed again.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (conditioner returns to released)
//   key_ni  raw asynchronous key, active-low
//   press_o one-cycle press pulse
module key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam logic [CNT_W-1:0] RunMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             last_q;
  logic [CNT_W-1:0] run_q, run_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic             same;
  logic             accept;

  // run_q is the length of the identical-sample run ending at last_q;
  // zero right after reset means no sample has been seen yet.
  always_comb begin
    same     = (sync2_q == last_q) && (run_q != '0);
    accept   = same && (run_q >= RunMax);
    run_d    = run_q;
    stable_d = stable_q;
    armed_d  = armed_q;
    if (!same) begin
      run_d = CNT_W'(1);
    end else if (run_q != RunMax) begin
      run_d = run_q + CNT_W'(1);
    end
    if (accept) begin
      stable_d = sync2_q;
      if (sync2_q) begin
        armed_d = 1'b1;
      end
    end
    press_d = stable_prev_q & ~stable_q & armed_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q       <= KeyReleased;
      sync2_q       <= KeyReleased;
      last_q        <= KeyReleased;
      run_q         <= '0;
      stable_q      <= KeyReleased;
      stable_prev_q <= KeyReleased;
      armed_q       <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      sync1_q       <= key_ni;
      sync2_q       <= sync1_q;
      last_q        <= sync2_q;
      run_q         <= run_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      armed_q       <= armed_d;
      press_q       <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the 4-digit BCD stopwatch.
// Conditions the start/lap/clear keys and runs the IDLE/RUN/STOP/LAP_RUN/
// LAP_STOP machine. Gates the divider tick into a registered count enable,
// issues clear and lap-capture pulses, and stops at 9999 with a sticky ovf.
// Ports:
//   clk         system clock
//   RST         asynchronous active-low reset
//   tick        one-cycle count strobe from the divider
//   key_*_n     raw active-low start/lap/clear keys
//   at_max      counter chain reads 9999
//   cnt_en      one-cycle increment enable to digit 0
//   cnt_clr     one-cycle synchronous clear to all digits
//   lap_load    one-cycle lap-register capture strobe
//   show_lap    display the lap register instead of the live count
//   running     counter advancing (RUN or LAP_RUN)
//   ovf         sticky overflow flag
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic RST,
  input  logic tick,
  input  logic key_start_n,
  input  logic key_lap_n,
  input  logic key_clr_n,
  input  logic at_max,
  output logic cnt_en,
  output logic cnt_clr,
  output logic lap_load,
  output logic show_lap,
  output logic running,
  output logic ovf
);

  logic start_p, lap_p, clr_p;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_start (
    .clk_i  (clk),
    .rst_ni (RST),
    .key_ni (key_start_n),
    .press_o(start_p)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_lap (
    .clk_i  (clk),
    .rst_ni (RST),
    .key_ni (key_lap_n),
    .press_o(lap_p)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_clr (
    .clk_i  (clk),
    .rst_ni (RST),
    .key_ni (key_clr_n),
    .press_o(clr_p)
  );

  sw_state_e state_q, state_d;
  logic      ovf_q, ovf_d;
  logic      cnt_en_q, cnt_en_d;
  logic      cnt_clr_q, cnt_clr_d;
  logic      lap_load_q, lap_load_d;

  // Presses are examined in clr > start > lap order, and a press the current
  // state ignores does not block a lower-priority one. An overflowing tick
  // takes precedence over any press in the running states.
  always_comb begin
    state_d    = state_q;
    ovf_d      = ovf_q;
    cnt_en_d   = 1'b0;
    cnt_clr_d  = 1'b0;
    lap_load_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_p) begin
          cnt_clr_d = 1'b1;
          ovf_d     = 1'b0;
        end else if (start_p) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (tick && at_max) begin
          state_d = StStop;
          ovf_d   = 1'b1;
        end else begin
          cnt_en_d = tick;
          if (start_p) begin
            state_d = StStop;
          end else if (lap_p) begin
            state_d    = StLapRun;
            lap_load_d = 1'b1;
          end
        end
      end
      StStop: begin
        if (clr_p) begin
          state_d   = StIdle;
          cnt_clr_d = 1'b1;
          ovf_d     = 1'b0;
        end else if (start_p && !ovf_q) begin
          state_d = StRun;
        end
      end
      StLapRun: begin
        if (tick && at_max) begin
          state_d = StLapStop;
          ovf_d   = 1'b1;
        end else begin
          cnt_en_d = tick;
          if (start_p) begin
            state_d = StLapStop;
          end else if (lap_p) begin
            state_d = StRun;
          end
        end
      end
      StLapStop: begin
        if (clr_p) begin
          state_d   = StIdle;
          cnt_clr_d = 1'b1;
          ovf_d     = 1'b0;
        end else if (start_p && !ovf_q) begin
          state_d = StLapRun;
        end else if (lap_p) begin
          state_d = StStop;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      ovf_q      <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      lap_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      lap_load_q <= lap_load_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign lap_load = lap_load_q;
  assign ovf      = ovf_q;
  assign running  = state_is_running(state_q);
  assign show_lap = state_is_lap(state_q);

endmodule
